cnt_seq_checker: RTL and testbench

- Receive-side checker for the 4-bit free-running counter stream (0,1,…,15,0,…) produced by the team's counter blocks.
- Samples the count on each valid cycle and acquires lock after a run of correct increments.
- Once locked, flags any break in the modulo-2^WIDTH increment sequence, counts errors, and re-seeks lock.
- Sits at the consuming end of the count interface, in loopback benches or on a downstream clock-enabled datapath.

---
 rtl/cnt_seq_pkg.sv | 24 ++
 rtl/cnt_seq_checker_sat_counter.sv | 33 +++
 rtl/cnt_seq_checker.sv | 138 +++++++++++++
 tb/tb_cnt_seq_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_pkg.sv
// Shared definitions for the counter-sequence checker: FSM encoding,
// default parameter values and the modulo increment helper.
package cnt_seq_pkg;

    typedef enum logic {
        SEEK = 1'b0,
        LOCK = 1'b1
    } cnt_seq_state_e;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_LOCK_CNT = 3;
    localparam int DEF_ERR_W    = 8;

    // Run-length counter width; wide enough for LOCK_CNT up to 15.
    localparam int MATCH_W = 4;

    // Increment v by one and wrap modulo 2^w (w below 32).
    function automatic logic [31:0] mod_inc(input logic [31:0] v, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (v + 32'd1) & mask[31:0];
    endfunction

endpackage

// File: rtl/cnt_seq_checker_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] count_q;
    logic [ERR_W-1:0] count_d;

    // Next count: add one on inc unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && !(&count_q)) begin
            count_d = count_q + ERR_W'(1);
        end
    end

    // Count register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cnt_seq_checker.sv
// Receive-side checker for a free-running modulo-2^WIDTH count stream.
// Acquires lock after LOCK_CNT correct increments, then flags and counts
// any break in the sequence and drops back to seeking lock.
// Optional build macro CNT_SEQ_CHECKER_STICKY_EN adds o_err_sticky, set with
// the first o_err and cleared only by rst.
module cnt_seq_checker
    import cnt_seq_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_locked,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [WIDTH-1:0] o_expect
`ifdef CNT_SEQ_CHECKER_STICKY_EN
    ,
    output logic             o_err_sticky
`endif
);

    cnt_seq_state_e     state_q, state_d;
    logic               have_prev_q, have_prev_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIDTH-1:0]   expect_q, expect_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   prev_inc;
    logic [WIDTH-1:0]   cnt_inc;
    logic [MATCH_W:0]   match_inc;
    logic               hit;

    assign prev_inc  = WIDTH'(mod_inc(32'(prev_q), WIDTH));
    assign cnt_inc   = WIDTH'(mod_inc(32'(i_cnt), WIDTH));
    assign match_inc = {1'b0, match_q} + (MATCH_W+1)'(1);
    // A held value or any jump is a miss; the wrap to 0 is a hit.
    assign hit       = (i_cnt == prev_inc);

    // Next-state logic: lock acquisition, loss detection and history update.
    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        match_d     = match_q;
        expect_d    = expect_q;
        err_d       = 1'b0;

        if (i_valid) begin
            // Every sample, even a bad one, becomes the new reference.
            prev_d      = i_cnt;
            expect_d    = cnt_inc;
            have_prev_d = 1'b1;

            case (state_q)
                SEEK: begin
                    if (!have_prev_q) begin
                        match_d = '0;
                    end else if (hit) begin
                        if (match_inc == (MATCH_W+1)'(LOCK_CNT)) begin
                            state_d = LOCK;
                            match_d = '0;
                        end else begin
                            match_d = match_inc[MATCH_W-1:0];
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCK: begin
                    if (!hit) begin
                        err_d   = 1'b1;
                        state_d = SEEK;
                        match_d = '0;
                    end
                end
            endcase
        end
    end

    // State registers with synchronous reset discarding all history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEEK;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            match_q     <= '0;
            expect_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            match_q     <= match_d;
            expect_q    <= expect_d;
            err_q       <= err_d;
        end
    end

    sat_counter #(
        .ERR_W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_d),
        .count (o_err_cnt)
    );

`ifdef CNT_SEQ_CHECKER_STICKY_EN
    logic sticky_q, sticky_d;

    // Sticky flag latches the first lock-loss until reset.
    always_comb begin
        sticky_d = sticky_q | err_d;
    end

    // Sticky register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign o_err_sticky = sticky_q;
`endif

    assign o_locked = (state_q == LOCK);
    assign o_err    = err_q;
    assign o_expect = expect_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed testbench for cnt_seq_checker (WIDTH=4, LOCK_CNT=3, ERR_W=8).
module tb_cnt_seq_checker;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic [3:0] i_cnt;
    logic       o_locked;
    logic       o_err;
    logic [7:0] o_err_cnt;
    logic [3:0] o_expect;
`ifdef CNT_SEQ_CHECKER_STICKY_EN
    logic       o_err_sticky;
`endif

    int total;
    int bad;
    int errs;
    logic [3:0] base;

    cnt_seq_checker dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_cnt     (i_cnt),
        .o_locked  (o_locked),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt),
        .o_expect  (o_expect)
`ifdef CNT_SEQ_CHECKER_STICKY_EN
        ,
        .o_err_sticky (o_err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic v, input logic [3:0] c);
        i_valid = v;
        i_cnt   = c;
        @(posedge clk);
        #1;
        $display("t=%0t valid=%0d cnt=%0d -> locked=%0d err=%0d err_cnt=%0d expect=%0d",
                 $time, v, c, o_locked, o_err, o_err_cnt, o_expect);
    endtask

    task automatic chk_out(input string tag, input logic lk, input logic er,
                           input int ec, input int ex);
        chk({tag, ".locked"},  32'(o_locked),  32'(lk));
        chk({tag, ".err"},     32'(o_err),     32'(er));
        chk({tag, ".err_cnt"}, 32'(o_err_cnt), 32'(ec));
        chk({tag, ".expect"},  32'(o_expect),  32'(ex));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        errs  = 0;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_cnt   = 4'd5;

        // Reset with valid toggling: everything stays zero.
        step(1'b1, 4'd5);
        chk_out("rst0", 1'b0, 1'b0, 0, 0);
        step(1'b0, 4'd5);
        chk_out("rst1", 1'b0, 1'b0, 0, 0);
        rst = 1'b0;

        // Acquire lock with 0,1,2,3.
        step(1'b1, 4'd0);
        chk_out("acq0", 1'b0, 1'b0, 0, 1);
        step(1'b1, 4'd1);
        chk_out("acq1", 1'b0, 1'b0, 0, 2);
        step(1'b1, 4'd2);
        chk_out("acq2", 1'b0, 1'b0, 0, 3);
        step(1'b1, 4'd3);
        chk_out("acq3", 1'b1, 1'b0, 0, 4);

        // Count through the wrap 15 -> 0 -> 1 while locked.
        for (int v = 4; v <= 17; v++) begin
            step(1'b1, 4'(v));
            chk_out("wrap", 1'b1, 1'b0, 0, (v + 1) % 16);
        end
        for (int v = 2; v <= 5; v++) begin
            step(1'b1, 4'(v));
            chk_out("run", 1'b1, 1'b0, 0, v + 1);
        end

        // Expect=6, feed 9: single error pulse, lock lost.
        step(1'b1, 4'd9);
        errs++;
        chk_out("jump", 1'b0, 1'b1, 1, 10);
        step(1'b1, 4'd10);
        chk_out("rel10", 1'b0, 1'b0, 1, 11);
        step(1'b1, 4'd11);
        chk_out("rel11", 1'b0, 1'b0, 1, 12);
        step(1'b1, 4'd12);
        chk_out("rel12", 1'b1, 1'b0, 1, 13);

        // Valid gap keeps everything, correct resume keeps lock.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'd0);
            chk_out("gap", 1'b1, 1'b0, 1, 13);
        end
        step(1'b1, 4'd13);
        chk_out("resume", 1'b1, 1'b0, 1, 14);

        // Gap then resend the same value: held value is an error.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'd7);
            chk_out("gap2", 1'b1, 1'b0, 1, 14);
        end
        step(1'b1, 4'd13);
        errs++;
        chk_out("held", 1'b0, 1'b1, 2, 14);

        // Relock, then two back-to-back misses give one pulse.
        step(1'b1, 4'd14);
        step(1'b1, 4'd15);
        step(1'b1, 4'd0);
        chk_out("relock", 1'b1, 1'b0, 2, 1);
        step(1'b1, 4'd7);
        errs++;
        chk_out("b2b0", 1'b0, 1'b1, 3, 8);
        step(1'b1, 4'd7);
        chk_out("b2b1", 1'b0, 1'b0, 3, 8);

        // Saturation: 300 more relock/error rounds.
        base = 4'd7;
        for (int n = 0; n < 300; n++) begin
            step(1'b1, base + 4'd1);
            step(1'b1, base + 4'd2);
            step(1'b1, base + 4'd3);
            chk("sat.locked", 32'(o_locked), 32'd1);
            step(1'b1, base + 4'd3);
            errs++;
            chk("sat.err", 32'(o_err), 32'd1);
            chk("sat.cnt", 32'(o_err_cnt), 32'((errs > 255) ? 255 : errs));
            base = base + 4'd3;
        end
        chk("sat.final", 32'(o_err_cnt), 32'd255);
`ifdef CNT_SEQ_CHECKER_STICKY_EN
        chk("sticky.set", 32'(o_err_sticky), 32'd1);
`endif

        // Relock, then reset mid-lock clears everything.
        step(1'b1, base + 4'd1);
        step(1'b1, base + 4'd2);
        step(1'b1, base + 4'd3);
        chk("prerst.locked", 32'(o_locked), 32'd1);
        rst = 1'b1;
        step(1'b1, 4'd3);
        rst = 1'b0;
        chk_out("midrst", 1'b0, 1'b0, 0, 0);
`ifdef CNT_SEQ_CHECKER_STICKY_EN
        chk("sticky.clr", 32'(o_err_sticky), 32'd0);
`endif

        // First sample after reset is only a reference, never an error.
        step(1'b1, 4'd9);
        chk_out("first", 1'b0, 1'b0, 0, 10);
        step(1'b1, 4'd2);
        chk_out("seekmiss", 1'b0, 1'b0, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
